ibex_rf_wb_arbiter: RTL and testbench
=====================================

IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter RV32E, default 0: when 1, addresses are 4 bits effective and bit 4 of any address is ignored.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: write data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive ALU losses before the ALU is promoted over MD.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports lsu_valid_i (input, 1), lsu_waddr_i (input, 5) and lsu_wdata_i (input, DATA_WIDTH): load writeback request, which cannot be back-pressured.
REQ-007 SHALL have ports md_valid_i (input, 1), md_waddr_i (input, 5), md_wdata_i (input, DATA_WIDTH) and md_ready_o (output, 1): multiply/divide writeback with valid/ready.
REQ-008 SHALL have ports alu_valid_i (input, 1), alu_waddr_i (input, 5), alu_wdata_i (input, DATA_WIDTH) and alu_ready_o (output, 1): ALU writeback with valid/ready.
REQ-009 SHALL have ports issue_valid_i (input, 1) and issue_rd_i (input, 5): an instruction issued that will write rd.
REQ-010 SHALL have ports raddr_a_i and raddr_b_i (input, 5 each), and hazard_a_o and hazard_b_o (output, 1 each): read-after-write hazard flags.
REQ-011 SHALL have ports rf_we_o (output, 1), rf_waddr_o (output, 5) and rf_wdata_o (output, DATA_WIDTH): the single register-file write port.
REQ-012 SHALL have port busy_o, output, 1: high when any scoreboard bit is set.

Function
REQ-013 Priority SHALL be LSU > MD > ALU, except that ALU SHALL win over MD when starve_cnt == STARVE_MAX; LSU always wins.
REQ-014 A handshake SHALL complete when valid && ready in the same cycle; LSU is granted whenever lsu_valid_i is high.
REQ-015 md_ready_o and alu_ready_o SHALL be combinational grant signals: at most one of lsu, md or alu is granted per cycle.
REQ-016 The granted request SHALL be registered and appear on rf_we_o/rf_waddr_o/rf_wdata_o exactly 1 cycle later (latency 1, one write per cycle).
REQ-017 A granted request to address 0 SHALL complete its handshake but drive rf_we_o=0.
REQ-018 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating, each cycle alu_valid_i is high and the ALU is not granted.
REQ-019 starve_cnt SHALL clear on an ALU grant or when alu_valid_i is low.
REQ-020 Scoreboard SHALL hold one pending bit per register 1..NUM_WORDS-1; bit 0 is constant 0.
REQ-021 issue_valid_i SHALL set pending[issue_rd_i] at the next edge; issue_rd_i=0 is ignored.
REQ-022 A write committed on rf_we_o SHALL clear pending[rf_waddr_o] at the same edge it is presented.
REQ-023 On a same-cycle set and clear of the same register, set SHALL win.
REQ-024 hazard_a_o SHALL equal pending[raddr_a_i] combinationally (likewise hazard_b_o), with no bypass from the write in flight.
REQ-025 Issuing to an already-pending register SHALL leave it pending; the count is not tracked, and the first writeback clears it.
REQ-026 Two-state FSM SHALL be IDLE (scoreboard empty) and BUSY (any bit pending); busy_o = (state == BUSY).
REQ-027 FSM SHALL move IDLE->BUSY on a valid set, and BUSY->IDLE when the next scoreboard value is all-zero.

Reset
REQ-028 Reset SHALL be asynchronous on negedge rst_n and clear rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, starve_cnt=0, all pending bits=0 and state=IDLE.
REQ-029 During reset, hazard_a_o, hazard_b_o and busy_o SHALL read 0, and md_ready_o/alu_ready_o SHALL follow the combinational grant.
REQ-030 Reset mid-operation SHALL drop any registered write without asserting rf_we_o.

Structure
REQ-031 Package ibex_defines SHALL hold the FSM state enum (WB_IDLE, WB_BUSY) and a wb_src enum (WB_LSU, WB_MD, WB_ALU, WB_NONE).
REQ-032 One sub-module, ibex_rf_scoreboard, SHALL hold the pending bits, the set/clear logic and the hazard lookups; the arbitration, starvation counter and output register SHALL sit at top level.

Verification
REQ-033 Bench SHALL apply lsu, md and alu valid in the same cycle, to x5, x6 and x7 -> lsu granted; the next cycle shows rf_we_o=1 and rf_waddr_o=5; md_ready_o=0 and alu_ready_o=0.
REQ-034 Bench SHALL hold md and alu valid continuously with STARVE_MAX=4 -> MD granted in cycles 0-3, ALU granted in cycle 4, then starve_cnt=0.
REQ-035 Bench SHALL issue rd=10, then raddr_a_i=10 -> hazard_a_o=1 until the cycle after the x10 write appears on rf_we_o, then 0; busy_o follows.
REQ-036 Bench SHALL apply issue rd=3 and a commit of x3 in the same cycle -> pending[3] stays 1 and hazard asserted on x3.
REQ-037 Bench SHALL make an ALU write to x0 with data 0xDEADBEEF -> alu_ready_o=1, rf_we_o stays 0 and hazard on raddr 0 is never asserted.
REQ-038 Bench SHALL assert rst_n low while pending bits and a registered write exist -> outputs cleared immediately, busy_o=0, and no write after release.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states and writeback source.
package ibex_defines;
  typedef enum logic {WB_IDLE, WB_BUSY} wb_state_e;
  typedef enum logic [1:0] {WB_LSU, WB_MD, WB_ALU, WB_NONE} wb_src_e;
endpackage

// File: rtl/ibex_rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on commit, with combinational RAW hazard lookup for two read ports.
module ibex_rf_scoreboard
  import ibex_defines::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] raddr_a,
  input  logic [4:0] raddr_b,
  output logic       hazard_a,
  output logic       hazard_b,
  output logic       set_hit,
  output logic       pend_nxt_any
);
  localparam int NUM_WORDS = RV32E ? 16 : 32;
  localparam int AW        = RV32E ? 4 : 5;

  logic [NUM_WORDS-1:1] pend_q;
  logic [NUM_WORDS-1:0] pend_full, pend_d;
  logic [AW-1:0]        set_idx, clr_idx, ra_idx, rb_idx;

  assign set_idx   = set_addr[AW-1:0];
  assign clr_idx   = clr_addr[AW-1:0];
  assign ra_idx    = raddr_a[AW-1:0];
  assign rb_idx    = raddr_b[AW-1:0];
  assign pend_full = {pend_q, 1'b0};
  assign set_hit   = set_en && (set_idx != '0);

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    pend_d = pend_full;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_hit) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d[NUM_WORDS-1:1];
  end

  assign pend_nxt_any = |pend_d;
  assign hazard_a     = pend_full[ra_idx];
  assign hazard_b     = pend_full[rb_idx];
endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file writeback arbiter: LSU > MD > ALU with ALU anti-starvation,
// one registered write per cycle, and a pending-write scoreboard for hazards.
module ibex_rf_wb_arbiter
  import ibex_defines::*;
#(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid_i,
  input  logic [4:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  md_valid_i,
  input  logic [4:0]            md_waddr_i,
  input  logic [DATA_WIDTH-1:0] md_wdata_i,
  output logic                  md_ready_o,
  input  logic                  alu_valid_i,
  input  logic [4:0]            alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  output logic                  alu_ready_o,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  busy_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_src_e               src;
  logic [SW-1:0]         starve_q;
  logic                  alu_prio;
  logic [4:0]            sel_addr, sel_eff;
  logic [DATA_WIDTH-1:0] sel_data;
  wb_state_e             state_q, state_d;
  logic                  set_hit, pend_nxt_any;

  assign alu_prio = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    src = WB_NONE;
    if (lsu_valid_i)                    src = WB_LSU;
    else if (md_valid_i && alu_valid_i) src = alu_prio ? WB_ALU : WB_MD;
    else if (md_valid_i)                src = WB_MD;
    else if (alu_valid_i)               src = WB_ALU;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (src)
      WB_LSU:  begin sel_addr = lsu_waddr_i; sel_data = lsu_wdata_i; end
      WB_MD:   begin sel_addr = md_waddr_i;  sel_data = md_wdata_i;  end
      WB_ALU:  begin sel_addr = alu_waddr_i; sel_data = alu_wdata_i; end
      default: ;
    endcase
  end

  assign sel_eff     = RV32E ? {1'b0, sel_addr[3:0]} : sel_addr;
  assign md_ready_o  = (src == WB_MD);
  assign alu_ready_o = (src == WB_ALU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                starve_q <= '0;
    else if (!alu_valid_i || src == WB_ALU)    starve_q <= '0;
    else if (!alu_prio)                        starve_q <= starve_q + SW'(1);
  end

  // x0 writes still consume the grant but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= (src != WB_NONE) && (sel_eff != 5'd0);
      if (src != WB_NONE) begin
        rf_waddr_o <= sel_eff;
        rf_wdata_o <= sel_data;
      end
    end
  end

  ibex_rf_scoreboard #(.RV32E(RV32E)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (issue_valid_i),
    .set_addr     (issue_rd_i),
    .clr_en       (rf_we_o),
    .clr_addr     (rf_waddr_o),
    .raddr_a      (raddr_a_i),
    .raddr_b      (raddr_b_i),
    .hazard_a     (hazard_a_o),
    .hazard_b     (hazard_b_o),
    .set_hit      (set_hit),
    .pend_nxt_any (pend_nxt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: if (set_hit) state_d = WB_BUSY;
      WB_BUSY: if (!pend_nxt_any) state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == WB_BUSY);
  end
endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural writeback/scoreboard model.
module tb_ibex_rf_wb_arbiter;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lsu_valid_i = 0, md_valid_i = 0, alu_valid_i = 0, issue_valid_i = 0;
  logic [4:0]    lsu_waddr_i = 0, md_waddr_i = 0, alu_waddr_i = 0, issue_rd_i = 0;
  logic [4:0]    raddr_a_i = 0, raddr_b_i = 0;
  logic [DW-1:0] lsu_wdata_i = 0, md_wdata_i = 0, alu_wdata_i = 0;
  logic          md_ready_o, alu_ready_o, hazard_a_o, hazard_b_o, rf_we_o, busy_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;

  ibex_rf_wb_arbiter #(.RV32E(1'b0), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .md_valid_i(md_valid_i), .md_waddr_i(md_waddr_i), .md_wdata_i(md_wdata_i), .md_ready_o(md_ready_o),
    .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i), .alu_ready_o(alu_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: pending set per register, one registered write, ALU loss counter.
  bit          m_pend[32];
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_starve;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 0; m_waddr = 0; m_wdata = '0; m_starve = 0;
  endtask

  // 0=LSU 1=MD 2=ALU 3=none
  function automatic int m_grant();
    if (lsu_valid_i) return 0;
    if (md_valid_i && alu_valid_i) return (m_starve == SMAX) ? 2 : 1;
    if (md_valid_i) return 1;
    if (alu_valid_i) return 2;
    return 3;
  endfunction

  task automatic idle_inputs();
    lsu_valid_i = 0; md_valid_i = 0; alu_valid_i = 0; issue_valid_i = 0;
  endtask

  // Check the current cycle against the model, then advance both by one edge.
  task automatic tick();
    int g;
    bit any;
    #2;
    g = m_grant();
    any = 0;
    foreach (m_pend[i]) any |= m_pend[i];
    chk("md_ready", 64'(md_ready_o), 64'(g == 1));
    chk("alu_ready", 64'(alu_ready_o), 64'(g == 2));
    chk("hazard_a", 64'(hazard_a_o), 64'(m_pend[raddr_a_i]));
    chk("hazard_b", 64'(hazard_b_o), 64'(m_pend[raddr_b_i]));
    chk("busy", 64'(busy_o), 64'(any));
    chk("rf_we", 64'(rf_we_o), 64'(m_we));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr_o), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata_o), 64'(m_wdata));
    end
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (issue_valid_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
    if (alu_valid_i && g != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else m_starve = 0;
    case (g)
      0: begin m_we = (lsu_waddr_i != 0); m_waddr = lsu_waddr_i; m_wdata = lsu_wdata_i; end
      1: begin m_we = (md_waddr_i != 0);  m_waddr = md_waddr_i;  m_wdata = md_wdata_i;  end
      2: begin m_we = (alu_waddr_i != 0); m_waddr = alu_waddr_i; m_wdata = alu_wdata_i; end
      default: m_we = 0;
    endcase
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    // During reset: outputs cleared, ready still follows the grant.
    md_valid_i = 1; md_waddr_i = 5'd4;
    #3;
    chk("rst_rf_we", 64'(rf_we_o), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr_o), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_hazard_a", 64'(hazard_a_o), 64'd0);
    chk("rst_md_ready", 64'(md_ready_o), 64'd1);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // All three sources at once: LSU wins.
    lsu_valid_i = 1; lsu_waddr_i = 5; lsu_wdata_i = 32'h1111_0005;
    md_valid_i  = 1; md_waddr_i  = 6; md_wdata_i  = 32'h2222_0006;
    alu_valid_i = 1; alu_waddr_i = 7; alu_wdata_i = 32'h3333_0007;
    #1;
    chk("tri_md_ready", 64'(md_ready_o), 64'd0);
    chk("tri_alu_ready", 64'(alu_ready_o), 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("tri_rf_we", 64'(rf_we_o), 64'd1);
    chk("tri_rf_waddr", 64'(rf_waddr_o), 64'd5);
    tick();

    // MD and ALU held: MD for four cycles, ALU on the fifth, then MD again.
    md_valid_i = 1; md_waddr_i = 8; alu_valid_i = 1; alu_waddr_i = 9;
    for (int c = 0; c < 6; c++) begin
      md_wdata_i = 32'hA000 + c; alu_wdata_i = 32'hB000 + c;
      #1;
      chk($sformatf("starve_alu_c%0d", c), 64'(alu_ready_o), 64'(c == 4));
      tick();
    end
    idle_inputs();
    tick();

    // RAW hazard on x10 until the cycle after its write is presented.
    raddr_a_i = 10; raddr_b_i = 11;
    issue_valid_i = 1; issue_rd_i = 10;
    tick();
    issue_valid_i = 0;
    #1;
    chk("x10_hazard_set", 64'(hazard_a_o), 64'd1);
    chk("x10_busy_set", 64'(busy_o), 64'd1);
    tick();
    alu_valid_i = 1; alu_waddr_i = 10; alu_wdata_i = 32'h0000_0A0A;
    tick();
    idle_inputs();
    #1;
    chk("x10_we", 64'(rf_we_o), 64'd1);
    chk("x10_hazard_inflight", 64'(hazard_a_o), 64'd1);
    tick();
    #1;
    chk("x10_hazard_clr", 64'(hazard_a_o), 64'd0);
    chk("x10_busy_clr", 64'(busy_o), 64'd0);
    tick();

    // Same-cycle set and clear of x3: set wins.
    raddr_a_i = 3;
    issue_valid_i = 1; issue_rd_i = 3;
    tick();
    issue_valid_i = 0; alu_valid_i = 1; alu_waddr_i = 3; alu_wdata_i = 32'h33;
    tick();
    alu_valid_i = 0; issue_valid_i = 1; issue_rd_i = 3;
    tick();
    issue_valid_i = 0;
    #1;
    chk("x3_set_wins_hazard", 64'(hazard_a_o), 64'd1);
    chk("x3_set_wins_busy", 64'(busy_o), 64'd1);
    alu_valid_i = 1; alu_waddr_i = 3; alu_wdata_i = 32'h34;
    tick();
    idle_inputs();
    tick();
    tick();

    // ALU write to x0 is accepted but never reaches the register file.
    raddr_a_i = 0;
    alu_valid_i = 1; alu_waddr_i = 0; alu_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("x0_alu_ready", 64'(alu_ready_o), 64'd1);
    tick();
    idle_inputs();
    #1;
    chk("x0_rf_we", 64'(rf_we_o), 64'd0);
    chk("x0_hazard", 64'(hazard_a_o), 64'd0);
    issue_valid_i = 1; issue_rd_i = 0;
    tick();
    issue_valid_i = 0;
    #1;
    chk("x0_issue_hazard", 64'(hazard_a_o), 64'd0);
    tick();

    // Reset mid-operation with pending bits and a registered write.
    raddr_a_i = 12;
    issue_valid_i = 1; issue_rd_i = 12; tick();
    issue_rd_i = 13; tick();
    issue_valid_i = 0; lsu_valid_i = 1; lsu_waddr_i = 20; lsu_wdata_i = 32'h2020;
    tick();
    idle_inputs();
    #1;
    chk("mid_pre_we", 64'(rf_we_o), 64'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_we", 64'(rf_we_o), 64'd0);
    chk("mid_rst_waddr", 64'(rf_waddr_o), 64'd0);
    chk("mid_rst_wdata", 64'(rf_wdata_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_hazard", 64'(hazard_a_o), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("post_rst_we", 64'(rf_we_o), 64'd0);
    tick();
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      lsu_valid_i   = ($urandom_range(0, 3) == 0);
      md_valid_i    = $urandom_range(0, 1) == 1;
      alu_valid_i   = $urandom_range(0, 1) == 1;
      issue_valid_i = ($urandom_range(0, 4) < 2);
      lsu_waddr_i   = 5'($urandom_range(0, 7));
      md_waddr_i    = 5'($urandom_range(0, 7));
      alu_waddr_i   = 5'($urandom_range(0, 31));
      issue_rd_i    = 5'($urandom_range(0, 7));
      raddr_a_i     = 5'($urandom_range(0, 7));
      raddr_b_i     = 5'($urandom_range(0, 31));
      lsu_wdata_i   = $urandom;
      md_wdata_i    = $urandom;
      alu_wdata_i   = $urandom;
      tick();
    end
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
